divider_iterative: RTL



---
 rtl/rv32m_pkg.sv | 31 +++
 rtl/divider_iterative_if.sv | 39 +++
 rtl/divider_iterative_step.sv | 25 ++
 rtl/divider_iterative.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared RV32M execute-unit types and constants.
// Multiply/divide opcodes, divider FSM states, divide constants.
package rv32m_pkg;

  localparam int          XLEN      = 32;
  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES  = 32'hffff_ffff;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  // Encoded as funct3[1:0]: bit 0 = unsigned, bit 1 = remainder.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/divider_iterative_if.sv
// divider_iterative_if: start/busy/ready bundle between execute and divider.
// master = execute/hazard side, slave = divide unit.
interface divider_iterative_if #(
  parameter int XLEN = 32
) ();
  import rv32m_pkg::*;

  logic            start;
  logic            flush;
  div_op_e         div_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic [XLEN-1:0] result;
  logic            ready;
  logic            busy;

  modport master (
    output start,
    output flush,
    output div_opcode,
    output operand1,
    output operand2,
    input  result,
    input  ready,
    input  busy
  );

  modport slave (
    input  start,
    input  flush,
    input  div_opcode,
    input  operand1,
    input  operand2,
    output result,
    output ready,
    output busy
  );

endinterface

// File: rtl/divider_iterative_step.sv
// div_step: one radix-2 restoring divide iteration (combinational).
// In: rem (W+1), quo (W), divisor (W). Out: rem_next, quo_next.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] quo_next
);

  logic [W+1:0] sh;
  logic [W+1:0] trial;

  // One guard bit above the partial remainder keeps the trial
  // sign unambiguous for any divisor magnitude.
  always_comb begin
    sh       = {rem, quo[W-1]};
    trial    = sh - {2'b00, divisor};
    quo_next = {quo[W-2:0], ~trial[W+1]};
    rem_next = trial[W+1] ? sh[W:0] : trial[W:0];
  end

endmodule

// File: rtl/divider_iterative.sv
// divider_iterative: multi-cycle RV32M DIV/DIVU/REM/REMU, 1 bit per cycle.
// Ports: clk, rst (async, high), bus (slave: start/flush/op/operands -> result/ready/busy).
module divider_iterative
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  divider_iterative_if.slave bus
);

  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);
  localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic            neg_q, neg_d;
  logic            rsgn_q, rsgn_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            sgn_in;
  logic            rem_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;

  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign sgn_in = ~bus.div_opcode[0];
  assign rem_in = bus.div_opcode[1];
  assign a_neg  = sgn_in & bus.operand1[XLEN-1];
  assign b_neg  = sgn_in & bus.operand2[XLEN-1];

  // INT_MIN negates to itself, which is the correct unsigned magnitude.
  assign a_mag = a_neg ? -bus.operand1 : bus.operand1;
  assign b_mag = b_neg ? -bus.operand2 : bus.operand2;

  assign div_zero = (bus.operand2 == '0);
  assign ovf      = sgn_in
                  & (bus.operand1 == MIN_V)
                  & (bus.operand2 == '1);

  div_step #(
    .W(XLEN)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_next(step_rem),
    .quo_next(step_quo)
  );

  // neg_q/rsgn_q are only ever set for signed ops.
  assign q_fix = neg_q ? -step_quo : step_quo;
  assign r_fix = rsgn_q ? -step_rem[XLEN-1:0]
                        : step_rem[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rsgn_d   = rsgn_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = 1'b0;
    busy_d   = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.div_opcode;
          neg_d  = a_neg ^ b_neg;
          rsgn_d = a_neg;
          rem_d  = '0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          cnt_d  = '0;
          busy_d = 1'b1;
          unique case (1'b1)
            div_zero: begin
              result_d = rem_in ? bus.operand1 : '1;
              ready_d  = 1'b1;
              state_d  = DONE;
            end
            ovf: begin
              result_d = rem_in ? '0 : MIN_V;
              ready_d  = 1'b1;
              state_d  = DONE;
            end
            default: begin
              state_d = CALC;
            end
          endcase
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_d = op_q[1] ? r_fix : q_fix;
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush overrides everything, including a start in IDLE.
    if (bus.flush) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      busy_d   = 1'b0;
      result_d = result_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= DIV;
      neg_q    <= 1'b0;
      rsgn_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      op_q     <= op_d;
      neg_q    <= neg_d;
      rsgn_q   <= rsgn_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;

endmodule
